// File: rtl/mux_scan_rx_if.sv
// Bus between the display-multiplexer scanner (master) and mux_scan_rx (slave):
// raw strobe/digit inputs plus the published frame and error pulses.
interface mux_scan_rx_if;
   logic [5:0] power;
   logic [3:0] disp;
   logic [3:0] h2, h1, m2, m1, s2, s1;
   logic       frame_valid;
   logic       err_onehot, err_bcd, err_order, err_range;
   logic [7:0] err_count;

   modport master (
      output power, disp,
      input  h2, h1, m2, m1, s2, s1,
      input  frame_valid, err_onehot, err_bcd, err_order, err_range, err_count
   );

   modport slave (
      input  power, disp,
      output h2, h1, m2, m1, s2, s1,
      output frame_valid, err_onehot, err_bcd, err_order, err_range, err_count
   );
endinterface

// File: rtl/mux_scan_rx.sv
// Recovers complete hh:mm:ss frames from a multiplexed 6-digit BCD display scan.
// Optional publish-time range check enabled by `define MUX_SCAN_RX_RANGE_CHECK_EN.
module mux_scan_rx #(
   parameter int STABLE_CYCLES = 4
) (
   input logic         clk,
   input logic         rst_n,
   mux_scan_rx_if.slave bus
);

   // Counter starts at 0 on the second identical sample, so N samples means N-2.
   localparam logic [7:0] STROBE_AT = 8'(STABLE_CYCLES - 2);

   typedef enum logic {HUNT, COLLECT} state_t;

   logic [5:0] power_meta, power_sync;
   logic [3:0] disp_meta, disp_sync;
   logic [9:0] cur_sample, prev_sample;
   logic [7:0] stable_cnt;
   logic       sample_match, strobe;

   logic       is_onehot, range_ok;
   logic [2:0] digit_idx;

   state_t     state, state_next;
   logic [2:0] expected, expected_next;
   logic [3:0] shadow [6];
   logic       store_en, publish_en;
   logic       onehot_next, bcd_next, order_next, range_next;
   logic       err_range_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         power_meta <= '0;
         power_sync <= '0;
         disp_meta  <= '0;
         disp_sync  <= '0;
      end else begin
         power_meta <= bus.power;
         power_sync <= power_meta;
         disp_meta  <= bus.disp;
         disp_sync  <= disp_meta;
      end
   end

   assign cur_sample   = {power_sync, disp_sync};
   assign sample_match = (cur_sample == prev_sample);
   assign strobe       = sample_match && (stable_cnt == STROBE_AT);

   // Saturating the counter above STROBE_AT guarantees a single strobe per held value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sample <= '0;
         stable_cnt  <= '0;
      end else begin
         prev_sample <= cur_sample;
         if (!sample_match)
            stable_cnt <= '0;
         else if (stable_cnt != 8'hFF)
            stable_cnt <= stable_cnt + 8'd1;
      end
   end

   always_comb begin
      digit_idx = '0;
      for (int i = 0; i < 6; i++)
         if (power_sync[i]) digit_idx = 3'(i);
   end

   assign is_onehot = (power_sync != 6'd0) && ((power_sync & (power_sync - 6'd1)) == 6'd0);

`ifdef MUX_SCAN_RX_RANGE_CHECK_EN
   // h2 arrives live with the final strobe; the other digits are already in shadow.
   assign range_ok = (shadow[1] <= 4'd5) && (shadow[3] <= 4'd5) && (disp_sync <= 4'd2) &&
                     !((disp_sync == 4'd2) && (shadow[4] > 4'd3));
`else
   assign range_ok = 1'b1;
`endif

   always_comb begin
      state_next    = state;
      expected_next = expected;
      store_en      = 1'b0;
      publish_en    = 1'b0;
      onehot_next   = 1'b0;
      bcd_next      = 1'b0;
      order_next    = 1'b0;
      range_next    = 1'b0;
      if (strobe && (power_sync != 6'd0)) begin
         if (!is_onehot) begin
            onehot_next   = 1'b1;
            state_next    = HUNT;
            expected_next = '0;
         end else if (disp_sync > 4'd9) begin
            bcd_next      = 1'b1;
            state_next    = HUNT;
            expected_next = '0;
         end else begin
            case (state)
               HUNT: begin
                  if (digit_idx == 3'd0) begin
                     store_en      = 1'b1;
                     expected_next = 3'd1;
                     state_next    = COLLECT;
                  end
               end
               COLLECT: begin
                  if (digit_idx == expected) begin
                     store_en = 1'b1;
                     if (digit_idx == 3'd5) begin
                        state_next    = HUNT;
                        expected_next = '0;
                        publish_en    = range_ok;
                        range_next    = !range_ok;
                     end else begin
                        expected_next = expected + 3'd1;
                     end
                  end else if (digit_idx == 3'd0) begin
                     order_next    = 1'b1;
                     store_en      = 1'b1;
                     expected_next = 3'd1;
                  end else begin
                     order_next    = 1'b1;
                     state_next    = HUNT;
                     expected_next = '0;
                  end
               end
               default: begin
                  state_next    = HUNT;
                  expected_next = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         expected <= '0;
         for (int i = 0; i < 6; i++) shadow[i] <= '0;
      end else begin
         state    <= state_next;
         expected <= expected_next;
         if (store_en) shadow[digit_idx] <= disp_sync;
      end
   end

   // Publishing on the index-5 strobe edge takes h2 straight from the synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.h2          <= '0;
         bus.h1          <= '0;
         bus.m2          <= '0;
         bus.m1          <= '0;
         bus.s2          <= '0;
         bus.s1          <= '0;
         bus.frame_valid <= 1'b0;
         bus.err_onehot  <= 1'b0;
         bus.err_bcd     <= 1'b0;
         bus.err_order   <= 1'b0;
         err_range_q     <= 1'b0;
         bus.err_count   <= '0;
      end else begin
         bus.frame_valid <= publish_en;
         bus.err_onehot  <= onehot_next;
         bus.err_bcd     <= bcd_next;
         bus.err_order   <= order_next;
         err_range_q     <= range_next;
         if (publish_en) begin
            bus.h2 <= disp_sync;
            bus.h1 <= shadow[4];
            bus.m2 <= shadow[3];
            bus.m1 <= shadow[2];
            bus.s2 <= shadow[1];
            bus.s1 <= shadow[0];
         end
         if ((bus.err_onehot || bus.err_bcd || bus.err_order || err_range_q) &&
             (bus.err_count != 8'hFF))
            bus.err_count <= bus.err_count + 8'd1;
      end
   end

`ifdef MUX_SCAN_RX_RANGE_CHECK_EN
   assign bus.err_range = err_range_q;
`else
   assign bus.err_range = 1'b0;
`endif

endmodule
